// File: rtl/fp_pkg.sv
// Shared binary64 constants and rounding-mode encoding for the FP adder back end.
package fp_pkg;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } rm_e;

   localparam int EXP_MAX = 2047;
   localparam int BIAS    = 1023;

   localparam logic [63:0] POS_INF    = 64'h7FF0_0000_0000_0000;
   localparam logic [63:0] MAX_FINITE = 64'h7FEF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/fp_add_normround_if.sv
// Beat interface between the significand adder, the normalize/round back end and the result mux.
interface fp_add_normround_if #(
   parameter int EW = 11,
   parameter int FW = 52
);
   logic             in_valid;
   logic             in_ready;
   logic [FW+4:0]    fs;
   logic             fszero;
   logic             ss;
   logic             sx;
   logic [EW-1:0]    er;
   logic [1:0]       rm;
   logic             out_valid;
   logic             out_ready;
   logic [EW+FW:0]   result;
   logic [2:0]       flags;

   modport slave (
      input  in_valid, fs, fszero, ss, sx, er, rm, out_ready,
      output in_ready, out_valid, result, flags
   );

   modport master (
      output in_valid, fs, fszero, ss, sx, er, rm, out_ready,
      input  in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/lzc56.sv
// Combinational leading-zero count of a 56-bit vector; returns 56 when the vector is zero.
module lzc56 (
   input  logic [55:0] a_i,
   output logic [5:0]  cnt_o
);
   // Scanning upward lets the most significant set bit write last and win.
   always_comb begin
      cnt_o = 6'd56;
      for (int i = 0; i < 56; i++) begin
         if (a_i[i]) cnt_o = 6'(55 - i);
      end
   end
endmodule

// File: rtl/fp_add_normround.sv
// Two-stage normalize (stage 1) and round/pack (stage 2) back end of the binary64 adder.
module fp_add_normround
   import fp_pkg::*;
#(
   parameter int EW = 11,
   parameter int FW = 52
) (
   input logic               clk,
   input logic               rst,
   fp_add_normround_if.slave bus
);
   localparam int XW = EW + 2;
   localparam int MW = FW + 4;
   localparam logic signed [XW-1:0] EXP_OVF = XW'(EXP_MAX);

   logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic                 s2_load, in_acc;
   logic [5:0]           lz, shamt;
   logic signed [XW-1:0] er_s, lim, exp1_d, s1_exp_q, exp2;
   logic [MW-1:0]        norm_d, s1_norm_q;
   logic                 sign_d, s1_sign_q, s1_zero_q;
   rm_e                  s1_rm_q;
   logic                 g, r, st, inexact, inc, tiny, ovf, inf_sel;
   logic [FW+1:0]        sum;
   logic [FW-1:0]        frac;
   logic [EW+FW:0]       res_d, s2_res_q;
   logic [2:0]           flags_d, s2_flags_q;

   assign s2_load       = ~s2_valid_q | bus.out_ready;
   assign bus.in_ready  = ~s1_valid_q | s2_load;
   assign in_acc        = bus.in_valid & bus.in_ready;
   assign s1_valid_d    = in_acc | (s1_valid_q & ~s2_load);
   assign s2_valid_d    = s2_load ? s1_valid_q : s2_valid_q;
   assign bus.out_valid = s2_valid_q;
   assign bus.result    = s2_res_q;
   assign bus.flags     = s2_flags_q;

   lzc56 u_lzc (
      .a_i   (bus.fs[MW-1:0]),
      .cnt_o (lz)
   );

   // Left shift is capped at er-1 so the exponent never drops below 1; leftover zeros mean denormal.
   always_comb begin
      er_s  = XW'(bus.er);
      lim   = er_s - XW'(1);
      shamt = ($signed({{(XW-6){1'b0}}, lz}) < lim) ? lz : lim[5:0];
      if (bus.fs[MW]) begin
         norm_d = {bus.fs[MW:2], bus.fs[1] | bus.fs[0]};
         exp1_d = er_s + XW'(1);
      end else begin
         norm_d = bus.fs[MW-1:0] << shamt;
         exp1_d = er_s - XW'(shamt);
      end
      sign_d = (bus.fszero & bus.sx) ? (bus.rm == RM_RDN) : bus.ss;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_norm_q  <= '0;
         s1_exp_q   <= '0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_rm_q    <= RM_RNE;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_acc) begin
            s1_norm_q <= norm_d;
            s1_exp_q  <= exp1_d;
            s1_sign_q <= sign_d;
            s1_zero_q <= bus.fszero;
            s1_rm_q   <= rm_e'(bus.rm);
         end
      end
   end

   always_comb begin
      g       = s1_norm_q[2];
      r       = s1_norm_q[1];
      st      = s1_norm_q[0];
      inexact = g | r | st;
      inc     = 1'b0;
      case (s1_rm_q)
         RM_RNE: inc = g & (r | st | s1_norm_q[3]);
         RM_RTZ: inc = 1'b0;
         RM_RUP: inc = ~s1_sign_q & inexact;
         RM_RDN: inc = s1_sign_q & inexact;
      endcase
      sum  = {1'b0, s1_norm_q[MW-1:3]} + (FW+2)'(inc);
      tiny = ~s1_norm_q[MW-1];
      frac = sum[FW-1:0];
      exp2 = s1_exp_q;
      // A denormal that rounds into the hidden bit keeps its exponent of 1; one that doesn't packs as 0.
      if (sum[FW+1]) begin
         exp2 = s1_exp_q + XW'(1);
         frac = '0;
      end else if (!sum[FW]) begin
         exp2 = '0;
      end
      ovf     = exp2 >= EXP_OVF;
      inf_sel = (s1_rm_q == RM_RNE) | ((s1_rm_q == RM_RUP) & ~s1_sign_q)
              | ((s1_rm_q == RM_RDN) & s1_sign_q);
      res_d   = {s1_sign_q, exp2[EW-1:0], frac};
      flags_d = {1'b0, tiny & inexact, inexact};
      if (s1_zero_q) begin
         res_d   = {s1_sign_q, {(EW+FW){1'b0}}};
         flags_d = 3'b000;
      end else if (ovf) begin
         res_d   = {s1_sign_q, inf_sel ? POS_INF[EW+FW-1:0] : MAX_FINITE[EW+FW-1:0]};
         flags_d = 3'b101;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_flags_q <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load & s1_valid_q) begin
            s2_res_q   <= res_d;
            s2_flags_q <= flags_d;
         end
      end
   end
endmodule

// File: doc/fp_add_normround.md
# fp_add_normround

Normalize-and-round back end of the double-precision adder: consumes the 57-bit signed-magnitude significand sum, zero flag and result sign from the significand-add stage, plus the larger operand's exponent. Produces a packed IEEE-754 binary64 result and exception flags. Two-stage pipeline with valid/ready flow control; sits between the significand adder and the FPU result mux.

## Interface
Parameters:
- `EW`, 11: exponent width
- `FW`, 52: stored fraction width

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  stage 1 can accept
- `fs`  in  57  magnitude from adder:
  - [56] carry-out
  - [55] hidden-bit position
  - [54:3] fraction
  - [2] guard, [1] round, [0] sticky
- `fszero`  in  1  exact zero sum
- `ss`  in  1  result sign from adder
- `sx`  in  1  effective subtraction
- `er`  in  11  biased exponent of larger operand (denormals pre-mapped to 1; 0 only with `fszero`)
- `rm`  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP, 11 RDN
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts
- `result`  out  64  packed binary64
- `flags`  out  3  {overflow, underflow, inexact}

## Operation
- **Stage 1 (normalize):**
  - `fs[56]=1`: shift right 1, exponent `er+1`, sticky |= shifted-out bit.
  - Else: `lz` = leading zeros of `fs[55:0]`; shift left by `min(lz, er-1)`; exponent `er - shift`.
  - Exponent carried as 13-bit signed.
  - Residual `fs[55]=0` after a limited shift marks a denormal; packed exponent is 0.
- **Stage 2 (round/pack):**
  - Round increment from LSB, G, R|S, sign and `rm`:
    - RNE: G&(R|S|LSB)
    - RTZ: 0
    - RUP: ~sign&(G|R|S)
    - RDN: sign&(G|R|S)
  - inexact = G|R|S.
  - Mantissa carry-out: exponent+1, fraction 0.
  - Denormal rounding up into hidden bit: exponent becomes 1.
- **Overflow** (exponent ≥ 2047 after rounding): overflow=1, inexact=1. Result by mode:
  - RNE: ±inf.
  - RTZ: ±max finite (0x7FEFFFFFFFFFFFFF with sign).
  - RUP: +inf or -max.
  - RDN: -inf or +max.
- **Underflow:** underflow=1 iff result tiny (packed exponent 0 before rounding) and inexact.
- **Zero (`fszero=1`):** result ±0, flags 000.
  - Sign = `ss` when `sx=0`.
  - Sign = (rm==RDN) when `sx=1`.
- Stage registers hold one beat each; no reordering.

## Timing
- Latency: result valid 2 cycles after acceptance when `out_ready` is held high.
- Throughput: one beat per cycle.
- Stage advance:
  - stage 2 loads when `~out_valid | out_ready`.
  - `in_ready = ~s1_valid | s2_can_load` (combinational from `out_ready`, no bubble).
- Handshake rules:
  - Transfer occurs only on `valid&ready`.
  - `result`/`flags` stable while `out_valid & ~out_ready`.
  - Inputs sampled only on input transfer.
- Full pipeline (2 beats) with `out_ready=0`: `in_ready=0`.
- Simultaneous output drain and input accept on a full pipeline: both beats move; no loss.
- Reset: asserting `rst` at any time clears `s1_valid`, `s2_valid`, `out_valid`, `result`, `flags` to 0 immediately. In-flight beats are discarded. `in_ready=1` after reset.

## Structure
- Shared package `fp_pkg`:
  - rounding-mode enum (`RM_RNE`, `RM_RTZ`, `RM_RUP`, `RM_RDN`)
  - `EXP_MAX=2047`, `BIAS=1023`
  - constants `POS_INF`, `MAX_FINITE`
- One sub-module `lzc56`: combinational 56-bit leading-zero counter, 6-bit output, 56 when all zero.

## Test plan
- 1.0+1.0: `fs={1'b1,56'b0}`, `er=0x3FF`, RNE → `result=0x4000000000000000`, flags 000, 2-cycle latency.
- Tie to even:
  - `fs[55]=1`, `fs[3]=1`, `fs[2:0]=100`, `er=0x3FF`, RNE → `0x3FF0000000000002`, inexact=1.
  - Same with RTZ → `0x3FF0000000000001`.
- Cancellation: `fszero=1`, `sx=1`, `ss=1`, `er=0x400`:
  - RNE → `0x0000000000000000`
  - RDN → `0x8000000000000000`
- Overflow: `fs[56]=1`, `er=0x7FE`, `ss=0`:
  - RNE → `0x7FF0000000000000`, flags 101
  - RTZ → `0x7FEFFFFFFFFFFFFF`, flags 101
- Denormal: `fs={3'b0,1'b1,53'b0}`, `er=1` → no shift, `0x0004000000000000`, flags 000.
- Backpressure/reset:
  - 3 back-to-back beats with `out_ready=0`: first two accepted, `in_ready=0` on third.
  - Release `out_ready`: results emerge in order, no duplicates.
  - `rst` pulse mid-stream: `out_valid=0` same cycle; no stale beat emerges afterward.
